data_mem_arb: RTL and testbench
===============================

Name: data_mem_arb

Overview:
- Parametrised successor to the single-port data memory monitor.
- Arbitrates NCH requester channels onto one shared single-port RAM.
- Adds byte-enable writes, a configurable read latency and per-channel read-valid routing.
- Adds address range checking that is visible in hardware, not only in simulation.
- Sits between the stream processing engines and on-chip data storage.

Parameters:
- NCH, 4, number of requester channels (1..8)
- DM_AW, 10, address width
- DM_DW, 32, data width; must be a multiple of 8
- RAM_DEPTH, 1<<DM_AW, number of physical words; must be <= 2^DM_AW
- RD_LAT, 1, read latency from grant edge to rdata_vld (1..4)
- BE_W, DM_DW/8, byte-enable width (derived)

Ports:
- clk  input  1  clock
- rst  input  1  reset
- ch_req  input  NCH  per-channel request; held until granted
- ch_wr  input  NCH  per-channel 1=write, 0=read
- ch_addr  input  NCH*DM_AW  channel i occupies bits [i*DM_AW +: DM_AW]
- ch_wdata  input  NCH*DM_DW  write data, packed the same way
- ch_be  input  NCH*BE_W  byte enables, packed the same way
- ch_gnt  output  NCH  one-hot grant, combinational from ch_req
- rdata  output  DM_DW  shared read data; zero when no valid
- rdata_vld  output  NCH  one-hot: the read data belongs to this channel
- err_oor  output  1  one-cycle pulse on an out-of-range access
- err_addr  output  DM_AW  address of the last out-of-range access

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All state changes on posedge clk.
- Reset values:
  - ch_gnt=0 while rst=1.
  - rdata_vld=0, rdata=0, err_oor=0, err_addr=0.
  - Round-robin pointer=0.
  - RAM contents are not reset.
- Arbitration:
  - Round-robin, starting at the pointer and searching upward with wrap.
  - At most one grant bit per cycle, and only to a channel with ch_req=1.
  - A transfer occurs when ch_req[i] & ch_gnt[i].
  - After a transfer the pointer moves to (winner+1) mod NCH. With no transfer the pointer holds.
- Write:
  - Bytes with be set are written at the grant edge; other bytes are unchanged.
  - be=0 is accepted but changes nothing.
  - Writes produce no rdata_vld.
- Read:
  - The RAM is read at the grant edge.
  - rdata_vld[i]=1 for exactly one cycle, RD_LAT cycles after the grant cycle. With RD_LAT=1 it is the cycle after the grant.
  - The read pipeline is RD_LAT-1 extra register stages carrying data, the channel id and a valid bit. It is fully pipelined: one read per cycle, results in grant order.
- Ordering: a read granted in the cycle after a write to the same address returns the new data. There is no same-cycle conflict because the RAM is single-port with one grant per cycle.
- Out of range (addr >= RAM_DEPTH; use >=, not <=):
  - Writes are suppressed.
  - Reads still produce rdata_vld, with rdata=0.
  - err_oor pulses the cycle after the grant.
  - err_addr captures the offending address and holds it until the next error.
- Idle: no request means no grant, the pointer holds and there is no RAM access.
- Reset mid-operation: in-flight reads are dropped and no rdata_vld appears after reset deasserts. The first grant after reset goes to the lowest requesting channel.
- Monitor: simulation-only read and write display lines, kept inside translate_off/on, printing channel id, address and data.

Decomposition:
- Package: dm_pkg holding default constants and a localparam function for the channel-id width (clog2(NCH), minimum 1).
- Sub-module rr_arbiter (NCH parameter):
  - Inputs: req and an advance strobe.
  - Outputs: one-hot gnt and the encoded winner id.
  - Reusable by other multi-channel blocks.
- RAM storage: a byte-enable RAM array, inferred in this module.

Test Plan:
- Single channel, RD_LAT=1:
  - Write ch0 addr 0x005 data 0xDEADBEEF be=0xF.
  - Next cycle read ch0 addr 0x005.
  - Expect rdata_vld=0b0001 and rdata=0xDEADBEEF one cycle after the read grant.
- Byte enable: write addr 0x010 = 0x11223344 with be=0xF, then write 0xAABBCCDD with be=0x5, then read -> 0x11BB33DD.
- Fairness:
  - Channels 0..3 request reads continuously from reset.
  - Expect grants 0,1,2,3,0,1,... on consecutive cycles.
  - Expect rdata_vld to follow the same sequence delayed by RD_LAT.
- Latency sweep:
  - RD_LAT=3, back-to-back reads of addr 1,2,3 from ch2.
  - Expect rdata_vld[2] on three consecutive cycles, exactly 3 cycles after each grant, with data in order.
- Out of range:
  - RAM_DEPTH=768, DM_AW=10. Write addr 0x300, then read 0x300.
  - Expect err_oor pulse with err_addr=0x300 on each access, read rdata=0, and no RAM change (verified by reading addr 0x000 before and after).
- Reset mid-flight:
  - RD_LAT=4, issue a read, assert rst for 1 cycle two cycles later.
  - Expect no rdata_vld afterwards, all outputs 0 during reset, and first grant to the lowest requester.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared defaults and helpers for the data memory arbiter family.
package dm_pkg;

    localparam int DM_NCH_DEF    = 4;
    localparam int DM_AW_DEF     = 10;
    localparam int DM_DW_DEF     = 32;
    localparam int DM_RD_LAT_DEF = 1;

    // Channel-id width; a single channel still needs one bit to carry an id.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded winner, pointer moves past the winner.
// Latency: grant is combinational from req; the pointer updates on the adv edge.
// Backpressure: requesters hold req until granted; no adv keeps the pointer in place.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic           adv,
    output logic [NCH-1:0] gnt,
    output logic [IDW-1:0] gnt_id
);

    logic [IDW-1:0]   ptr;
    logic [2*NCH-1:0] req2;
    logic [NCH-1:0]   rot;
    logic [IDW-1:0]   off;
    logic [IDW:0]     sum;
    logic             found;

    // Rotate so the pointer position lands on bit 0, then pick the lowest set bit.
    assign req2 = {req, req} >> ptr;
    assign rot  = req2[NCH-1:0];

    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = IDW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDW+1)'(NCH)) begin
            gnt_id = IDW'(sum - (IDW+1)'(NCH));
        end else begin
            gnt_id = IDW'(sum);
        end
        gnt = found ? (NCH'(1) << gnt_id) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (gnt_id == IDW'(NCH - 1)) ? '0 : gnt_id + IDW'(1);
        end
    end

endmodule

// File: rtl/data_mem_arb.sv
// Shares one byte-enable single-port RAM between NCH channels with round-robin grants.
// Latency: grant combinational; read data and rdata_vld RD_LAT cycles after the grant edge.
// Backpressure: a channel holds ch_req until ch_gnt; reads are fully pipelined, one per cycle.
module data_mem_arb
    import dm_pkg::*;
#(
    parameter int NCH       = DM_NCH_DEF,
    parameter int DM_AW     = DM_AW_DEF,
    parameter int DM_DW     = DM_DW_DEF,
    parameter int RAM_DEPTH = 1 << DM_AW,
    parameter int RD_LAT    = DM_RD_LAT_DEF,
    parameter int BE_W      = DM_DW / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       ch_req,
    input  logic [NCH-1:0]       ch_wr,
    input  logic [NCH*DM_AW-1:0] ch_addr,
    input  logic [NCH*DM_DW-1:0] ch_wdata,
    input  logic [NCH*BE_W-1:0]  ch_be,
    output logic [NCH-1:0]       ch_gnt,
    output logic [DM_DW-1:0]     rdata,
    output logic [NCH-1:0]       rdata_vld,
    output logic                 err_oor,
    output logic [DM_AW-1:0]     err_addr
);

    localparam int IDW    = id_width(NCH);
    localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    typedef struct packed {
        logic             vld;
        logic [IDW-1:0]   id;
        logic [DM_DW-1:0] dat;
    } rd_stage_t;

    logic [NCH-1:0]    arb_gnt;
    logic [IDW-1:0]    arb_id;
    logic              xfer, oor, do_wr, do_rd, err_q;
    logic              sel_wr;
    logic [DM_AW-1:0]  sel_addr;
    logic [DM_DW-1:0]  sel_wdata;
    logic [BE_W-1:0]   sel_be;
    logic [RAM_AW-1:0] ram_idx;
    logic [DM_DW-1:0]  mem [RAM_DEPTH];
    rd_stage_t         rd_pipe [RD_LAT];
    rd_stage_t         rd_out;

    rr_arbiter #(
        .NCH (NCH),
        .IDW (IDW)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (ch_req),
        .adv    (xfer),
        .gnt    (arb_gnt),
        .gnt_id (arb_id)
    );

    assign ch_gnt = rst ? '0 : arb_gnt;
    assign xfer   = |(ch_req & ch_gnt);

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (arb_id == IDW'(i)) begin
                sel_wr    = ch_wr[i];
                sel_addr  = ch_addr[i*DM_AW +: DM_AW];
                sel_wdata = ch_wdata[i*DM_DW +: DM_DW];
                sel_be    = ch_be[i*BE_W +: BE_W];
            end
        end
    end

    // Physical depth may be smaller than the address space; anything at or above it is rejected.
    assign oor     = {1'b0, sel_addr} >= (DM_AW+1)'(RAM_DEPTH);
    assign ram_idx = sel_addr[RAM_AW-1:0];
    assign do_wr   = xfer & sel_wr & ~oor;
    assign do_rd   = xfer & ~sel_wr;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            for (int b = 0; b < BE_W; b++) begin
                if (sel_be[b]) begin
                    mem[ram_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT; s++) begin
                rd_pipe[s] <= '0;
            end
        end else begin
            rd_pipe[0].vld <= do_rd;
            rd_pipe[0].id  <= arb_id;
            rd_pipe[0].dat <= (do_rd && !oor) ? mem[ram_idx] : '0;
            for (int s = 1; s < RD_LAT; s++) begin
                rd_pipe[s] <= rd_pipe[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q    <= 1'b0;
            err_addr <= '0;
        end else begin
            err_q <= xfer & oor;
            if (xfer && oor) begin
                err_addr <= sel_addr;
            end
        end
    end

    assign rd_out    = rd_pipe[RD_LAT-1];
    assign rdata_vld = (rd_out.vld && !rst) ? (NCH'(1) << rd_out.id) : '0;
    assign rdata     = (rd_out.vld && !rst) ? rd_out.dat : '0;
    assign err_oor   = err_q & ~rst;

endmodule

// File: tb/tb_data_mem_arb.sv
// Bench: three arbiters (read latency 1/3/4, depth 768/1024/1024) share one stimulus stream.
module tb_data_mem_arb;

    localparam int LAT   [3] = '{1, 3, 4};
    localparam int DEPTH [3] = '{768, 1024, 1024};

    typedef struct {
        logic [3:0]  req;
        bit          wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  exp_gnt;
    } vec_t;

    typedef struct { int inst; int due; int ch; logic [31:0] dat; } rd_exp_t;
    typedef struct { int inst; int due; logic [9:0] addr; } err_exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_s, wr_s;
    logic [39:0]  addr_s;
    logic [127:0] wdata_s;
    logic [15:0]  be_s;

    logic [3:0]  gnt   [3];
    logic [31:0] rdata [3];
    logic [3:0]  vld   [3];
    logic        err   [3];
    logic [9:0]  eaddr [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] mdl [3][1024];
    logic [9:0]  exp_eaddr [3];
    rd_exp_t     rdq [$];
    err_exp_t    erq [$];
    vec_t        tbl [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_arb #(.NCH(4), .DM_AW(10), .DM_DW(32), .RAM_DEPTH(768), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .ch_req(req_s), .ch_wr(wr_s), .ch_addr(addr_s),
        .ch_wdata(wdata_s), .ch_be(be_s), .ch_gnt(gnt[0]), .rdata(rdata[0]),
        .rdata_vld(vld[0]), .err_oor(err[0]), .err_addr(eaddr[0]));

    data_mem_arb #(.NCH(4), .DM_AW(10), .DM_DW(32), .RAM_DEPTH(1024), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .ch_req(req_s), .ch_wr(wr_s), .ch_addr(addr_s),
        .ch_wdata(wdata_s), .ch_be(be_s), .ch_gnt(gnt[1]), .rdata(rdata[1]),
        .rdata_vld(vld[1]), .err_oor(err[1]), .err_addr(eaddr[1]));

    data_mem_arb #(.NCH(4), .DM_AW(10), .DM_DW(32), .RAM_DEPTH(1024), .RD_LAT(4)) u_dut4 (
        .clk(clk), .rst(rst), .ch_req(req_s), .ch_wr(wr_s), .ch_addr(addr_s),
        .ch_wdata(wdata_s), .ch_be(be_s), .ch_gnt(gnt[2]), .rdata(rdata[2]),
        .rdata_vld(vld[2]), .err_oor(err[2]), .err_addr(eaddr[2]));

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%h expected=%h", nm, k, cyc, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] r, input bit w, input logic [9:0] a,
                                input logic [31:0] d, input logic [3:0] b, input logic [3:0] g);
        vec_t v;
        v.req = r; v.wr = w; v.addr = a; v.wdata = d; v.be = b; v.exp_gnt = g;
        return v;
    endfunction

    // Drive one cycle of requests, check the grant, and update the model at the grant edge.
    task automatic step(input vec_t v);
        int  id;
        bit  oor;
        req_s = v.req;
        wr_s  = v.wr ? 4'hF : 4'h0;
        for (int i = 0; i < 4; i++) begin
            addr_s[i*10 +: 10]  = v.addr;
            wdata_s[i*32 +: 32] = v.wdata;
            be_s[i*4 +: 4]      = v.be;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("gnt", k, 32'(gnt[k]), 32'(v.exp_gnt));
        id = -1;
        for (int i = 0; i < 4; i++) if (v.exp_gnt[i]) id = i;
        if (id >= 0) begin
            for (int k = 0; k < 3; k++) begin
                oor = int'(v.addr) >= DEPTH[k];
                if (oor) erq.push_back('{k, cyc + 1, v.addr});
                if (v.wr) begin
                    if (!oor) begin
                        for (int b = 0; b < 4; b++)
                            if (v.be[b]) mdl[k][v.addr][b*8 +: 8] = v.wdata[b*8 +: 8];
                    end
                end else begin
                    rdq.push_back('{k, cyc + LAT[k], id, oor ? 32'h0 : mdl[k][v.addr]});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : mon
        logic [3:0]  ev;
        logic [31:0] ed;
        logic        ee;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    chk("rst_gnt", k, 32'(gnt[k]), 32'h0);
                    chk("rst_vld", k, 32'(vld[k]), 32'h0);
                    chk("rst_rdata", k, rdata[k], 32'h0);
                    chk("rst_err", k, 32'(err[k]), 32'h0);
                    exp_eaddr[k] = '0;
                end else begin
                    ev = '0; ed = '0; ee = 1'b0;
                    foreach (rdq[i]) if (rdq[i].inst == k && rdq[i].due == cyc) begin
                        ev = 4'(1) << rdq[i].ch;
                        ed = rdq[i].dat;
                    end
                    foreach (erq[i]) if (erq[i].inst == k && erq[i].due == cyc) begin
                        ee = 1'b1;
                        exp_eaddr[k] = erq[i].addr;
                    end
                    chk("rdata_vld", k, 32'(vld[k]), 32'(ev));
                    chk("rdata", k, rdata[k], ed);
                    chk("err_oor", k, 32'(err[k]), 32'(ee));
                    chk("err_addr", k, 32'(eaddr[k]), 32'(exp_eaddr[k]));
                end
            end
            // Anything still in flight when reset is seen must never surface.
            if (rst) begin
                rdq.delete();
                erq.delete();
            end else begin
                for (int i = rdq.size() - 1; i >= 0; i--) if (rdq[i].due <= cyc) rdq.delete(i);
                for (int i = erq.size() - 1; i >= 0; i--) if (erq[i].due <= cyc) erq.delete(i);
            end
        end
    end

    initial begin
        rst = 1'b1; req_s = 4'hF; wr_s = '0; addr_s = '0; wdata_s = '0; be_s = '0;
        for (int k = 0; k < 3; k++) exp_eaddr[k] = '0;

        tbl.push_back(mk(4'b0001, 1, 10'h000, 32'h0BADF00D, 4'hF, 4'b0001));
        tbl.push_back(mk(4'b0001, 1, 10'h005, 32'hDEADBEEF, 4'hF, 4'b0001));
        tbl.push_back(mk(4'b0001, 0, 10'h005, 32'h0,        4'h0, 4'b0001));
        tbl.push_back(mk(4'b0010, 1, 10'h010, 32'h11223344, 4'hF, 4'b0010));
        tbl.push_back(mk(4'b0010, 1, 10'h010, 32'hAABBCCDD, 4'h5, 4'b0010));
        tbl.push_back(mk(4'b0010, 0, 10'h010, 32'h0,        4'h0, 4'b0010));
        tbl.push_back(mk(4'b1000, 1, 10'h010, 32'hFFFFFFFF, 4'h0, 4'b1000));
        tbl.push_back(mk(4'b1000, 0, 10'h010, 32'h0,        4'h0, 4'b1000));
        tbl.push_back(mk(4'b0000, 0, 10'h000, 32'h0,        4'h0, 4'b0000));
        tbl.push_back(mk(4'b1111, 0, 10'h005, 32'h0,        4'h0, 4'b0001));
        tbl.push_back(mk(4'b1111, 0, 10'h005, 32'h0,        4'h0, 4'b0010));
        tbl.push_back(mk(4'b1111, 0, 10'h005, 32'h0,        4'h0, 4'b0100));
        tbl.push_back(mk(4'b1111, 0, 10'h005, 32'h0,        4'h0, 4'b1000));
        tbl.push_back(mk(4'b1111, 0, 10'h005, 32'h0,        4'h0, 4'b0001));
        tbl.push_back(mk(4'b1111, 0, 10'h005, 32'h0,        4'h0, 4'b0010));
        tbl.push_back(mk(4'b0000, 0, 10'h000, 32'h0,        4'h0, 4'b0000));
        tbl.push_back(mk(4'b0100, 1, 10'h001, 32'h00000101, 4'hF, 4'b0100));
        tbl.push_back(mk(4'b0100, 1, 10'h002, 32'h00000202, 4'hF, 4'b0100));
        tbl.push_back(mk(4'b0100, 1, 10'h003, 32'h00000303, 4'hF, 4'b0100));
        tbl.push_back(mk(4'b0100, 0, 10'h001, 32'h0,        4'h0, 4'b0100));
        tbl.push_back(mk(4'b0100, 0, 10'h002, 32'h0,        4'h0, 4'b0100));
        tbl.push_back(mk(4'b0100, 0, 10'h003, 32'h0,        4'h0, 4'b0100));
        tbl.push_back(mk(4'b0000, 0, 10'h000, 32'h0,        4'h0, 4'b0000));
        tbl.push_back(mk(4'b0010, 0, 10'h000, 32'h0,        4'h0, 4'b0010));
        tbl.push_back(mk(4'b0010, 1, 10'h2FF, 32'hCAFE0001, 4'hF, 4'b0010));
        tbl.push_back(mk(4'b0010, 0, 10'h2FF, 32'h0,        4'h0, 4'b0010));
        tbl.push_back(mk(4'b0010, 1, 10'h300, 32'h12345678, 4'hF, 4'b0010));
        tbl.push_back(mk(4'b0010, 0, 10'h300, 32'h0,        4'h0, 4'b0010));
        tbl.push_back(mk(4'b0010, 0, 10'h000, 32'h0,        4'h0, 4'b0010));
        tbl.push_back(mk(4'b1010, 0, 10'h005, 32'h0,        4'h0, 4'b1000));
        tbl.push_back(mk(4'b0110, 0, 10'h005, 32'h0,        4'h0, 4'b0010));
        tbl.push_back(mk(4'b0011, 0, 10'h005, 32'h0,        4'h0, 4'b0001));

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; req_s = '0;

        foreach (tbl[i]) step(tbl[i]);

        // Read in flight on ch1 (pointer left at 2), reset sampled two edges after the grant.
        step(mk(4'b0010, 0, 10'h005, 32'h0, 4'h0, 4'b0010));
        req_s = '0;
        @(posedge clk);
        #1;
        rst = 1'b1; req_s = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b0; req_s = '0;
        repeat (6) step(mk(4'b0000, 0, 10'h000, 32'h0, 4'h0, 4'b0000));
        step(mk(4'b1010, 0, 10'h005, 32'h0, 4'h0, 4'b0010));
        step(mk(4'b1010, 0, 10'h005, 32'h0, 4'h0, 4'b1000));
        repeat (6) step(mk(4'b0000, 0, 10'h000, 32'h0, 4'h0, 4'b0000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
